// File: rtl/io_pkg.sv
// io_pkg: shared width default and IN handshake state type for io_responder.
package io_pkg;
    localparam int DATA_W = 8;
    typedef enum logic [1:0] {
        IN_IDLE = 2'd0,
        IN_WAIT = 2'd1,
        IN_ACK  = 2'd2
    } in_state_t;
endpackage

// File: rtl/io_fifo.sv
// io_fifo: power-of-two FIFO, no bypass, no push when full; head reads 0 while empty.
module io_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        din,
    input  logic                     pop,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic push_en, pop_en;
    assign count   = wr_ptr - rd_ptr;
    assign full    = count[AW];
    assign empty   = count == '0;
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (AW+1)'(push_en);
            rd_ptr <= rd_ptr + (AW+1)'(pop_en);
        end
    end
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/io_responder.sv
// io_responder: OUT/IN byte buffering between CPU handshake and external streams.
// Optional internal TX->RX loopback with IO_RESPONDER_LOOPBACK_EN.
module io_responder #(
    parameter int DATA_W = io_pkg::DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef IO_RESPONDER_LOOPBACK_EN
    input  logic                     loopback,
`endif
    input  logic                     cpu_out_valid,
    input  logic [DATA_W-1:0]        cpu_out_data,
    output logic                     cpu_out_ready,
    input  logic                     cpu_in_req,
    output logic [DATA_W-1:0]        cpu_in_data,
    output logic                     cpu_in_ack,
    output logic                     ext_tx_valid,
    output logic [DATA_W-1:0]        ext_tx_data,
    input  logic                     ext_tx_ready,
    input  logic                     ext_rx_valid,
    input  logic [DATA_W-1:0]        ext_rx_data,
    output logic                     ext_rx_ready,
    output logic [$clog2(DEPTH):0]   tx_count,
    output logic [$clog2(DEPTH):0]   rx_count
);
    import io_pkg::*;
    in_state_t state, state_nx;
    logic lb;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_pop, rx_push, rx_pop;
    logic [DATA_W-1:0] tx_head, rx_head, rx_din;
`ifdef IO_RESPONDER_LOOPBACK_EN
    // registered so the mode select never reaches an output combinationally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) lb <= 1'b0;
        else lb <= loopback;
    end
`else
    assign lb = 1'b0;
`endif
    assign tx_pop  = !tx_empty && (lb ? !rx_full : ext_tx_ready);
    assign rx_push = lb ? !tx_empty : ext_rx_valid;
    assign rx_din  = lb ? tx_head : ext_rx_data;
    assign rx_pop  = !rx_empty && (state == IN_WAIT || (state == IN_IDLE && cpu_in_req));
    assign cpu_out_ready = !tx_full;
    assign ext_tx_valid  = !tx_empty && !lb;
    assign ext_tx_data   = tx_head;
    assign ext_rx_ready  = !rx_full && !lb;
    assign cpu_in_ack    = state == IN_ACK;
    io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx (
        .clk(clk), .rst(rst),
        .push(cpu_out_valid), .din(cpu_out_data),
        .pop(tx_pop), .dout(tx_head),
        .full(tx_full), .empty(tx_empty), .count(tx_count)
    );
    io_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx (
        .clk(clk), .rst(rst),
        .push(rx_push), .din(rx_din),
        .pop(rx_pop), .dout(rx_head),
        .full(rx_full), .empty(rx_empty), .count(rx_count)
    );
    always_comb begin
        state_nx = state == IN_ACK ? IN_IDLE
                 : rx_pop ? IN_ACK
                 : (state == IN_IDLE && cpu_in_req) ? IN_WAIT
                 : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IN_IDLE;
            cpu_in_data <= '0;
        end else begin
            state <= state_nx;
            if (rx_pop) cpu_in_data <= rx_head;
        end
    end
endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: vector table plus scoreboarded sequences for io_responder.
module tb_io_responder;
    logic clk = 1'b0;
    logic rst;
    logic cpu_out_valid, cpu_out_ready, cpu_in_req, cpu_in_ack;
    logic [7:0] cpu_out_data, cpu_in_data, ext_tx_data, ext_rx_data;
    logic ext_tx_valid, ext_tx_ready, ext_rx_valid, ext_rx_ready;
    logic [2:0] tx_count, rx_count;
`ifdef IO_RESPONDER_LOOPBACK_EN
    logic loopback;
`endif

    io_responder #(.DATA_W(8), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
`ifdef IO_RESPONDER_LOOPBACK_EN
        .loopback(loopback),
`endif
        .cpu_out_valid(cpu_out_valid), .cpu_out_data(cpu_out_data), .cpu_out_ready(cpu_out_ready),
        .cpu_in_req(cpu_in_req), .cpu_in_data(cpu_in_data), .cpu_in_ack(cpu_in_ack),
        .ext_tx_valid(ext_tx_valid), .ext_tx_data(ext_tx_data), .ext_tx_ready(ext_tx_ready),
        .ext_rx_valid(ext_rx_valid), .ext_rx_data(ext_rx_data), .ext_rx_ready(ext_rx_ready),
        .tx_count(tx_count), .rx_count(rx_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int ack_seen = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    typedef struct {
        logic       ov;
        logic [7:0] d;
        logic       tr;
        logic       e_rdy;
        logic       e_tv;
        logic [7:0] e_head;
        logic [2:0] e_cnt;
    } tx_vec_t;
    tx_vec_t tv[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_ready"}, 32'(cpu_out_ready), 1);
        check({tag, "_rx_ready"}, 32'(ext_rx_ready), 1);
        check({tag, "_tx_valid"}, 32'(ext_tx_valid), 0);
        check({tag, "_ack"}, 32'(cpu_in_ack), 0);
        check({tag, "_in_data"}, 32'(cpu_in_data), 0);
        check({tag, "_tx_data"}, 32'(ext_tx_data), 0);
        check({tag, "_tx_count"}, 32'(tx_count), 0);
        check({tag, "_rx_count"}, 32'(rx_count), 0);
    endtask

    // Handshakes are stable between edges, so observe them at the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (cpu_out_valid && cpu_out_ready) tx_q.push_back(cpu_out_data);
            if (ext_rx_valid && ext_rx_ready) rx_q.push_back(ext_rx_data);
            if (ext_tx_valid && ext_tx_ready) begin
                if (tx_q.size() == 0) check("tx_unexpected", 32'(ext_tx_data), 32'hffff_ffff);
                else check("tx_order", 32'(ext_tx_data), 32'(tx_q.pop_front()));
            end
            if (cpu_in_ack) begin
                ack_seen++;
                if (rx_q.size() == 0) check("in_unexpected", 32'(cpu_in_data), 32'hffff_ffff);
                else check("in_order", 32'(cpu_in_data), 32'(rx_q.pop_front()));
            end
        end
    end

    initial begin
        int ack_base;
        rst = 1'b1;
        cpu_out_valid = 1'b0; cpu_out_data = 8'h00; cpu_in_req = 1'b0;
        ext_tx_ready = 1'b0; ext_rx_valid = 1'b0; ext_rx_data = 8'h00;
`ifdef IO_RESPONDER_LOOPBACK_EN
        loopback = 1'b0;
`endif
        tv[0] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 3'd1};
        tv[1] = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01, 3'd2};
        tv[2] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h01, 3'd3};
        tv[3] = '{1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4};
        tv[4] = '{1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4};
        tv[5] = '{1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 8'h02, 3'd3};
        tv[6] = '{1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 8'h03, 3'd3};
        tv[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 3'd2};
        tv[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h05, 3'd1};
        tv[9] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
        repeat (2) tick();
        check_reset_values("por");
        rst = 1'b0;

        // TX fill to full, blocked fifth byte, in-order drain
        for (int i = 0; i < 10; i++) begin
            cpu_out_valid = tv[i].ov;
            cpu_out_data  = tv[i].d;
            ext_tx_ready  = tv[i].tr;
            tick();
            check($sformatf("tx_vec%0d_ready", i), 32'(cpu_out_ready), 32'(tv[i].e_rdy));
            check($sformatf("tx_vec%0d_valid", i), 32'(ext_tx_valid), 32'(tv[i].e_tv));
            check($sformatf("tx_vec%0d_head", i), 32'(ext_tx_data), 32'(tv[i].e_head));
            check($sformatf("tx_vec%0d_count", i), 32'(tx_count), 32'(tv[i].e_cnt));
        end
        cpu_out_valid = 1'b0; ext_tx_ready = 1'b0;
        check("tx_drained", tx_q.size(), 0);

        // IN with empty RX: wait, byte arrives, ack one edge after acceptance
        ack_base = ack_seen;
        cpu_in_req = 1'b1;
        tick();
        check("wait_ack0", 32'(cpu_in_ack), 0);
        repeat (2) begin
            tick();
            check("wait_ack_idle", 32'(cpu_in_ack), 0);
        end
        ext_rx_valid = 1'b1; ext_rx_data = 8'h2A;
        tick();
        ext_rx_valid = 1'b0;
        check("wait_accept_ack0", 32'(cpu_in_ack), 0);
        check("wait_rx_count1", 32'(rx_count), 1);
        tick();
        cpu_in_req = 1'b0;
        check("wait_ack1", 32'(cpu_in_ack), 1);
        check("wait_data", 32'(cpu_in_data), 32'h2A);
        check("wait_rx_count0", 32'(rx_count), 0);
        tick();
        check("wait_ack_done", 32'(cpu_in_ack), 0);
        check("wait_data_hold", 32'(cpu_in_data), 32'h2A);
        check("wait_one_ack", ack_seen - ack_base, 1);

        // simultaneous IN pop and external push at rx_count = 2
        ext_rx_valid = 1'b1; ext_rx_data = 8'h31;
        tick();
        ext_rx_data = 8'h32;
        tick();
        ext_rx_valid = 1'b0;
        check("simul_pre_count", 32'(rx_count), 2);
        cpu_in_req = 1'b1; ext_rx_valid = 1'b1; ext_rx_data = 8'h33;
        tick();
        cpu_in_req = 1'b0; ext_rx_valid = 1'b0;
        check("simul_count_held", 32'(rx_count), 2);
        check("simul_ack", 32'(cpu_in_ack), 1);
        check("simul_data31", 32'(cpu_in_data), 32'h31);
        tick();
        cpu_in_req = 1'b1;
        tick();
        cpu_in_req = 1'b0;
        check("simul_data32", 32'(cpu_in_data), 32'h32);
        check("simul_count1", 32'(rx_count), 1);
        tick();
        cpu_in_req = 1'b1;
        tick();
        cpu_in_req = 1'b0;
        check("simul_data33", 32'(cpu_in_data), 32'h33);
        check("simul_count0", 32'(rx_count), 0);
        tick();

        // asynchronous reset with both FIFOs occupied
        cpu_out_valid = 1'b1; cpu_out_data = 8'hA1;
        tick();
        cpu_out_data = 8'hA2;
        tick();
        cpu_out_valid = 1'b0; ext_rx_valid = 1'b1; ext_rx_data = 8'hB1;
        tick();
        ext_rx_valid = 1'b0;
        check("pre_rst_tx_count", 32'(tx_count), 2);
        #2 rst = 1'b1;
        tx_q.delete(); rx_q.delete();
        #1;
        check_reset_values("mid");
        tick();
        rst = 1'b0;
        check_reset_values("post");
        cpu_out_valid = 1'b1; cpu_out_data = 8'h06; ext_tx_ready = 1'b1;
        tick();
        cpu_out_valid = 1'b0;
        check("out06_valid", 32'(ext_tx_valid), 1);
        check("out06_data", 32'(ext_tx_data), 32'h06);
        check("out06_count1", 32'(tx_count), 1);
        tick();
        ext_tx_ready = 1'b0;
        check("out06_valid0", 32'(ext_tx_valid), 0);
        check("out06_count0", 32'(tx_count), 0);

        // reset while an IN is waiting, request held across it
        ack_base = ack_seen;
        cpu_in_req = 1'b1;
        repeat (2) tick();
        #2 rst = 1'b1;
        tx_q.delete(); rx_q.delete();
        #1;
        check("rwait_ack_in_rst", 32'(cpu_in_ack), 0);
        tick();
        #2 rst = 1'b0;
        repeat (2) begin
            tick();
            check("rwait_ack0", 32'(cpu_in_ack), 0);
        end
        ext_rx_valid = 1'b1; ext_rx_data = 8'h11;
        tick();
        ext_rx_valid = 1'b0;
        check("rwait_accept_ack0", 32'(cpu_in_ack), 0);
        tick();
        cpu_in_req = 1'b0;
        check("rwait_ack1", 32'(cpu_in_ack), 1);
        check("rwait_data", 32'(cpu_in_data), 32'h11);
        tick();
        check("rwait_ack_done", 32'(cpu_in_ack), 0);
        check("rwait_one_ack", ack_seen - ack_base, 1);

`ifdef IO_RESPONDER_LOOPBACK_EN
        // internal loopback: OUT byte returns through IN, never seen externally
        loopback = 1'b1;
        tick();
        check("lb_tx_valid_a", 32'(ext_tx_valid), 0);
        check("lb_rx_ready", 32'(ext_rx_ready), 0);
        cpu_out_valid = 1'b1; cpu_out_data = 8'h5F;
        tick();
        cpu_out_valid = 1'b0;
        check("lb_tx_valid_b", 32'(ext_tx_valid), 0);
        check("lb_tx_count1", 32'(tx_count), 1);
        tick();
        check("lb_tx_valid_c", 32'(ext_tx_valid), 0);
        check("lb_tx_count0", 32'(tx_count), 0);
        check("lb_rx_count1", 32'(rx_count), 1);
        if (tx_q.size() != 0) rx_q.push_back(tx_q.pop_front());
        cpu_in_req = 1'b1;
        tick();
        cpu_in_req = 1'b0;
        check("lb_ack", 32'(cpu_in_ack), 1);
        check("lb_data", 32'(cpu_in_data), 32'h5F);
        check("lb_tx_valid_d", 32'(ext_tx_valid), 0);
        tick();
        loopback = 1'b0;
        tick();
`endif

        check("end_tx_q_empty", tx_q.size(), 0);
        check("end_rx_q_empty", rx_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
